uart_rx: RTL and testbench

//   UART receiver: 8N1 serial frames on rx, 16x oversampling, parallel byte out.

---
 rtl/uart_rx.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x oversampling.
// Serial rx and the baud sample strobe are synchronised into clk. Rising
// edges of the synced strobe form the tick that paces every counter. Each bit
// is judged from a single sample taken near its centre. Only frames with a
// valid stop bit update rx_data.
`timescale 1ps/1ps

module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_rate_sample_clk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Centre of the start bit, counted from the detected falling edge.
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    // One full bit period, counted from one bit centre to the next.
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Synchronisers and strobe edge detector
    logic                 rx_meta_r;
    logic                 rx_sync_r;
    logic                 strb_meta_r;
    logic                 strb_sync_r;
    logic                 strb_prev_r;
    logic                 tick_s;

    // FSM state and datapath registers
    state_t               state_r;
    state_t               state_nxt_s;
    logic [TW-1:0]        tick_cnt_r;
    logic [TW-1:0]        tick_cnt_nxt_s;
    logic [BW-1:0]        bit_cnt_r;
    logic [BW-1:0]        bit_cnt_nxt_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_nxt_s;
    logic [DATA_BITS-1:0] rx_data_r;
    logic [DATA_BITS-1:0] rx_data_nxt_s;
    logic                 rx_done_r;
    logic                 rx_done_nxt_s;

    // Two-flop synchronisers. rx presets high so reset looks like an idle line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_r   <= 1'b1;
            rx_sync_r   <= 1'b1;
            strb_meta_r <= 1'b0;
            strb_sync_r <= 1'b0;
            strb_prev_r <= 1'b0;
        end else begin
            rx_meta_r   <= rx;
            rx_sync_r   <= rx_meta_r;
            strb_meta_r <= baud_rate_sample_clk;
            strb_sync_r <= strb_meta_r;
            strb_prev_r <= strb_sync_r;
        end
    end

    // One-clk tick on each rising edge of the synchronised strobe.
    assign tick_s = strb_sync_r & ~strb_prev_r;

    // State and datapath register bank.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= {TW{1'b0}};
            bit_cnt_r  <= {BW{1'b0}};
            shift_r    <= {DATA_BITS{1'b0}};
            rx_data_r  <= {DATA_BITS{1'b0}};
            rx_done_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            tick_cnt_r <= tick_cnt_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            shift_r    <= shift_nxt_s;
            rx_data_r  <= rx_data_nxt_s;
            rx_done_r  <= rx_done_nxt_s;
        end
    end

    // Next-state and datapath logic. Counters move only on tick.
    always_comb begin
        state_nxt_s    = state_r;
        tick_cnt_nxt_s = tick_cnt_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        shift_nxt_s    = shift_r;
        rx_data_nxt_s  = rx_data_r;
        rx_done_nxt_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (rx_sync_r == 1'b0) begin
                    state_nxt_s    = ST_START;
                    tick_cnt_nxt_s = {TW{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_START: begin
                if (tick_s) begin
                    if (tick_cnt_r == HALF_LAST) begin
                        if (rx_sync_r == 1'b0) begin
                            state_nxt_s    = ST_DATA;
                            tick_cnt_nxt_s = {TW{1'b0}};
                            bit_cnt_nxt_s  = {BW{1'b0}};
                        end else begin
                            // Line went back high before mid start bit: a glitch.
                            state_nxt_s = ST_IDLE;
                        end
                    end else begin
                        tick_cnt_nxt_s = tick_cnt_r + TW'(1);
                    end
                end else begin
                    tick_cnt_nxt_s = tick_cnt_r;
                end
            end

            ST_DATA: begin
                if (tick_s) begin
                    if (tick_cnt_r == FULL_LAST) begin
                        tick_cnt_nxt_s = {TW{1'b0}};
                        shift_nxt_s    = {rx_sync_r, shift_r[DATA_BITS-1:1]};
                        if (bit_cnt_r == LAST_BIT) begin
                            state_nxt_s = ST_STOP;
                        end else begin
                            bit_cnt_nxt_s = bit_cnt_r + BW'(1);
                        end
                    end else begin
                        tick_cnt_nxt_s = tick_cnt_r + TW'(1);
                    end
                end else begin
                    tick_cnt_nxt_s = tick_cnt_r;
                end
            end

            ST_STOP: begin
                if (tick_s) begin
                    if (tick_cnt_r == FULL_LAST) begin
                        state_nxt_s    = ST_IDLE;
                        tick_cnt_nxt_s = {TW{1'b0}};
                        if (rx_sync_r == 1'b1) begin
                            rx_data_nxt_s = shift_r;
                            rx_done_nxt_s = 1'b1;
                        end else begin
                            // Framing error: the byte is discarded silently.
                            rx_data_nxt_s = rx_data_r;
                        end
                    end else begin
                        tick_cnt_nxt_s = tick_cnt_r + TW'(1);
                    end
                end else begin
                    tick_cnt_nxt_s = tick_cnt_r;
                end
            end

            default: begin
                state_nxt_s    = ST_IDLE;
                tick_cnt_nxt_s = {TW{1'b0}};
            end
        endcase
    end

    assign rx_data = rx_data_r;
    assign rx_done = rx_done_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx (8N1, 16x oversampling).
// clk 10 ps, sample strobe 250 ps, bit period 4 ns.
`timescale 1ps/1ps

module tb_uart_rx;

    logic       clk;
    logic       reset;
    logic       baud_rate_sample_clk;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;

    int         checks;
    int         errors;
    int         pulses;
    int         hi_cycles;
    logic       prev_done;
    longint     last_rise;
    longint     stop_start;
    int         p0;
    int         h0;
    int         lat;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk                  (clk),
        .reset                (reset),
        .baud_rate_sample_clk (baud_rate_sample_clk),
        .rx                   (rx),
        .rx_data              (rx_data),
        .rx_done              (rx_done)
    );

    // 10 ps system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 250 ps strobe, offset so its edges never coincide with clk edges
    initial begin
        baud_rate_sample_clk = 1'b0;
        #2;
        forever #125 baud_rate_sample_clk = ~baud_rate_sample_clk;
    end

    // Pulse monitor: counts rx_done pulses, high cycles, and last rise time
    initial begin
        pulses    = 0;
        hi_cycles = 0;
        prev_done = 1'b0;
        last_rise = 0;
        forever begin
            @(negedge clk);
            if (rx_done === 1'b1) begin
                hi_cycles = hi_cycles + 1;
                if (prev_done !== 1'b1) begin
                    pulses    = pulses + 1;
                    last_rise = $time;
                end
            end
            prev_done = rx_done;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start bit, 8 data bits LSB first, then a stop bit of given value/length
    task automatic send_frame(input logic [7:0] d, input logic stop_val, input int stop_len);
        rx = 1'b0;
        #4000;
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #4000;
        end
        stop_start = $time;
        rx = stop_val;
        #(stop_len);
        rx = 1'b1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        stop_start = 0;
        rx         = 1'b1;
        reset      = 1'b0;

        // 1. Reset with idle line
        #100;
        check("reset_rx_data", {24'd0, rx_data}, 32'h0000_0000);
        check("reset_rx_done", {31'd0, rx_done}, 32'h0000_0000);
        @(negedge clk);
        reset = 1'b1;
        #4000;
        @(negedge clk);
        check("idle_no_done", pulses, 32'd0);

        // 2. Single frame 0xB5
        p0 = pulses;
        h0 = hi_cycles;
        send_frame(8'hB5, 1'b1, 4000);
        #4000;
        check("b5_pulses", pulses - p0, 32'd1);
        check("b5_width", hi_cycles - h0, 32'd1);
        check("b5_data", {24'd0, rx_data}, 32'h0000_00B5);
        lat = int'(last_rise - stop_start);
        check("b5_latency_window", {31'd0, (lat >= 1500 && lat <= 2600)}, 32'd1);

        // 3. Short glitch on the line
        p0 = pulses;
        rx = 1'b0;
        #1000;
        rx = 1'b1;
        #6000;
        check("glitch_no_done", pulses - p0, 32'd0);
        check("glitch_data", {24'd0, rx_data}, 32'h0000_00B5);

        // 4. Framing error on 0x3C (stop low past its sample point)
        p0 = pulses;
        send_frame(8'h3C, 1'b0, 2500);
        #8000;
        check("frame_err_no_done", pulses - p0, 32'd0);
        check("frame_err_data", {24'd0, rx_data}, 32'h0000_00B5);

        // 5. Back-to-back 0x00 then 0xFF
        p0 = pulses;
        h0 = hi_cycles;
        send_frame(8'h00, 1'b1, 4000);
        check("b2b_first_data", {24'd0, rx_data}, 32'h0000_0000);
        send_frame(8'hFF, 1'b1, 4000);
        #4000;
        check("b2b_second_data", {24'd0, rx_data}, 32'h0000_00FF);
        check("b2b_pulses", pulses - p0, 32'd2);
        check("b2b_width", hi_cycles - h0, 32'd2);

        // 6. Reset during bit 4, then a clean 0xA5
        @(negedge clk);
        p0 = pulses;
        rx = 1'b0;
        #4000;
        for (int i = 0; i < 4; i++) begin
            rx = (i % 2 == 0) ? 1'b1 : 1'b0;
            #4000;
        end
        rx = 1'b1;
        #1000;
        reset = 1'b0;
        #1;
        check("midreset_data", {24'd0, rx_data}, 32'h0000_0000);
        check("midreset_done", {31'd0, rx_done}, 32'h0000_0000);
        #2000;
        @(negedge clk);
        reset = 1'b1;
        #4000;
        @(negedge clk);
        check("midreset_no_done", pulses - p0, 32'd0);
        p0 = pulses;
        send_frame(8'hA5, 1'b1, 4000);
        #4000;
        check("a5_data", {24'd0, rx_data}, 32'h0000_00A5);
        check("a5_pulses", pulses - p0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
